ulpi_reg_port: RTL and testbench
================================

Name: ulpi_reg_port

Overview:
ULPI link-side register access engine, clocked by the PHY's 60 MHz ULPI output clock. It replaces the ad-hoc read sequencing in the top level with a request/response port for single ULPI register reads and writes. Its upstream is the PHY reset/bring-up sequencer; its downstream consumer is the UART byte reporter. It also reports RX CMD bytes seen while the PHY owns the bus.

Parameters:
TIMEOUT_CYCLES, 255, max cycles to wait for nxt or dir before a transaction fails (8-bit counter)
MAX_RETRY, 3, automatic re-issues of a TXCMD aborted by PHY dir assertion before reporting failure

Ports:
clk  input  1  ULPI clock (PHY CLKOUT); only clock
reset  input  1  synchronous, active-low reset
req_valid  input  1  request strobe
req_ready  output  1  high only in IDLE with ulpi_dir=0
req_write  input  1  1=register write, 0=register read
req_addr  input  6  ULPI register address
req_wdata  input  8  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  8  read data, valid with rsp_valid
rsp_error  output  1  timeout or retries exhausted, valid with rsp_valid
ulpi_dir  input  1  PHY bus direction
ulpi_nxt  input  1  PHY throttle
ulpi_stp  output  1  link stop
ulpi_data_in  input  8  bus value from top-level tristate
ulpi_data_out  output  8  bus value to drive
ulpi_data_oe  output  1  drive enable = oe_reg AND NOT ulpi_dir (combinational, so the link releases in the same cycle dir rises)
rxcmd_valid  output  1  one-cycle pulse, RX CMD captured
rxcmd  output  8  last RX CMD byte

Behaviour:
- Reset (reset=0 at posedge): state=IDLE; ulpi_stp=0, ulpi_data_out=8'h00, oe_reg=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rxcmd_valid=0, rxcmd=0, retry/timeout counters=0. Reset mid-transaction takes effect the same edge; no stp is issued.
- Accept: req_valid & req_ready at posedge latches write/addr/wdata and moves to TXCMD. req_ready is low in every other state.
- TXCMD: drive {req_write?2'b10:2'b11, addr}, oe_reg=1. nxt=1 -> WDATA (write) or RTURN (read). dir=1 before nxt -> ABORT.
- WDATA: drive wdata. nxt=1 -> WSTP.
- WSTP: one cycle with stp=1, data=8'h00. Then DONE with rsp_error=0.
- RTURN: oe_reg=0. dir=1 -> RDATA. Otherwise wait.
- RDATA: if dir=1 & nxt=0, capture data_in into rsp_rdata and go to RWAIT. If dir=1 & nxt=1, the PHY aborted the read for a receive -> ABORT.
- RWAIT: wait for dir=0, then DONE.
- ABORT: oe_reg=0; wait for dir=0. Then, if retry count < MAX_RETRY: increment and return to TXCMD. Else DONE with rsp_error=1.
- DONE: rsp_valid=1 for exactly one cycle; rsp_rdata holds until the next read completes. Retry count clears. -> IDLE.
- Timeout: counter clears on every state change and increments while waiting in TXCMD, WDATA, RTURN or RWAIT. Reaching TIMEOUT_CYCLES: if oe_reg=1, drive one WSTP-style stp cycle first; then DONE with rsp_error=1.
- Read latency: minimum TXCMD-accept to rsp_valid is 5 cycles (nxt, turnaround, data, turnaround, done).
- RX CMD: outside RTURN/RDATA/RWAIT, a cycle with dir=1 following a cycle with dir=1 (i.e. not the turnaround cycle) and nxt=0 loads rxcmd and pulses rxcmd_valid. Cycles with dir=1 & nxt=1 are packet data and are ignored.
- ulpi_data_out=8'h00 whenever no command or data is being driven (ULPI idle).
- A request arriving while dir=1 waits; req_valid must be held until accepted.

Test Plan:
- Write addr 0x0A data 0x55; PHY nxt on cycles 1 and 2 -> bus shows 0x8A then 0x55, stp=1 with data 0x00 for one cycle, rsp_valid=1 with rsp_error=0.
- Read addr 0x00; PHY nxt, then dir=1 turnaround, then 0x24 with nxt=0, then dir=0 -> rsp_rdata=0x24, rsp_error=0, rsp_valid exactly 5 cycles after TXCMD 0xC0 is accepted.
- Read 0x03 with dir raised during TXCMD (before nxt) -> ulpi_data_oe=0 in that same cycle; TXCMD 0xC3 reissued after dir falls; PHY returns 0x00 -> success. Four consecutive aborts -> rsp_error=1.
- Read with PHY silent (no nxt) -> exactly one stp cycle, then rsp_valid with rsp_error=1 after TIMEOUT_CYCLES.
- In IDLE, PHY dir=1 turnaround, then byte 0x4C with nxt=0 -> rxcmd=0x4C, rxcmd_valid one cycle, req_ready=0 while dir=1.
- reset=0 asserted in RDATA -> next cycle state IDLE, oe=0, stp=0, no rsp_valid; a new read completes normally afterwards.

Source files
------------

// File: rtl/ulpi_reg_port_if.sv
// Request/response port for single ULPI register accesses.
// The requester takes master, the register engine takes slave.
interface ulpi_reg_port_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_error
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_error
  );
endinterface

// File: rtl/ulpi_reg_port.sv
// ULPI link-side register read/write engine with RX CMD capture.
// Runs entirely in the PHY CLKOUT domain.
module ulpi_reg_port #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic           clk,
  input  logic           reset,
  ulpi_reg_port_if.slave bus,
  input  logic           ulpi_dir,
  input  logic           ulpi_nxt,
  output logic           ulpi_stp,
  input  logic [7:0]     ulpi_data_in,
  output logic [7:0]     ulpi_data_out,
  output logic           ulpi_data_oe,
  output logic           rxcmd_valid,
  output logic [7:0]     rxcmd
);
  localparam int RW =
    (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [7:0]    TMO  = 8'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    IDLE, TXCMD, WDATA, WSTP,
    RTURN, RDATA, RWAIT, ABORT, DONE
  } state_t;

  state_t        state, state_n;
  logic          wr_q;
  logic [5:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    tcnt, tcnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic          err_q, err_n;
  logic [7:0]    rdata_q;
  logic          cap;
  logic          dir_q;
  logic          accept;
  logic          waiting;
  logic          tmo;
  logic          oe_reg;
  logic          rx_hit;

  assign bus.req_ready = (state == IDLE) & ~ulpi_dir;
  assign accept  = bus.req_valid & bus.req_ready;
  assign tmo     = (tcnt == TMO);
  assign waiting = state inside {TXCMD, WDATA, RTURN, RWAIT};

  // RX CMDs only outside a read turnaround, never on the turnaround cycle
  assign rx_hit = ulpi_dir & dir_q & ~ulpi_nxt &
                  ~(state inside {RTURN, RDATA, RWAIT});

  always_comb begin
    state_n = state;
    err_n   = err_q;
    rcnt_n  = rcnt;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = TXCMD;
          err_n   = 1'b0;
        end
      end
      TXCMD: begin
        if (ulpi_dir) state_n = ABORT;
        else if (ulpi_nxt) state_n = wr_q ? WDATA : RTURN;
        else if (tmo) begin
          state_n = WSTP;
          err_n   = 1'b1;
        end
      end
      WDATA: begin
        if (ulpi_nxt) state_n = WSTP;
        else if (tmo) begin
          state_n = WSTP;
          err_n   = 1'b1;
        end
      end
      WSTP: state_n = DONE;
      RTURN: begin
        if (ulpi_dir) state_n = RDATA;
        else if (tmo) begin
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      RDATA: begin
        // anything but a clean register byte is treated as an abort
        if (ulpi_dir && !ulpi_nxt) begin
          cap     = 1'b1;
          state_n = RWAIT;
        end else begin
          state_n = ABORT;
        end
      end
      RWAIT: begin
        if (!ulpi_dir) state_n = DONE;
        else if (tmo) begin
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      ABORT: begin
        if (!ulpi_dir) begin
          if (rcnt < RMAX) begin
            rcnt_n  = rcnt + RW'(1);
            state_n = TXCMD;
          end else begin
            state_n = DONE;
            err_n   = 1'b1;
          end
        end
      end
      DONE: begin
        rcnt_n  = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tcnt_n = tcnt;
    if (state_n != state) tcnt_n = 8'd0;
    else if (waiting) tcnt_n = tcnt + 8'd1;
  end

  always_comb begin
    ulpi_data_out = 8'h00;
    oe_reg        = 1'b0;
    unique case (state)
      TXCMD: begin
        ulpi_data_out = {wr_q ? 2'b10 : 2'b11, addr_q};
        oe_reg        = 1'b1;
      end
      WDATA: begin
        ulpi_data_out = wdata_q;
        oe_reg        = 1'b1;
      end
      WSTP:    oe_reg = 1'b1;
      default: oe_reg = 1'b0;
    endcase
  end

  assign ulpi_stp      = (state == WSTP);
  assign ulpi_data_oe  = oe_reg & ~ulpi_dir;
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_error = err_q;
  assign bus.rsp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= 6'd0;
      wdata_q     <= 8'd0;
      tcnt        <= 8'd0;
      rcnt        <= '0;
      err_q       <= 1'b0;
      rdata_q     <= 8'd0;
      dir_q       <= 1'b0;
      rxcmd_valid <= 1'b0;
      rxcmd       <= 8'd0;
    end else begin
      state       <= state_n;
      tcnt        <= tcnt_n;
      rcnt        <= rcnt_n;
      err_q       <= err_n;
      dir_q       <= ulpi_dir;
      rxcmd_valid <= rx_hit;
      if (accept) begin
        wr_q    <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (cap) rdata_q <= ulpi_data_in;
      if (rx_hit) rxcmd <= ulpi_data_in;
    end
  end
endmodule

// File: tb/tb_ulpi_reg_port.sv
// Directed bench for ulpi_reg_port: queued expected responses
// are checked by negedge monitors as the DUT presents them.
module tb_ulpi_reg_port;
  localparam int TMO_C = 255;

  typedef struct packed {
    logic       chk_d;
    logic [7:0] d;
    logic       err;
  } rsp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       ulpi_stp;
  logic [7:0] ulpi_data_in;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe;
  logic       rxcmd_valid;
  logic [7:0] rxcmd;

  int n_vec = 0;
  int n_bad = 0;

  rsp_t       rq[$];
  logic [7:0] xq[$];

  ulpi_reg_port_if bus();

  ulpi_reg_port #(
    .TIMEOUT_CYCLES(TMO_C),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .ulpi_dir(ulpi_dir),
    .ulpi_nxt(ulpi_nxt),
    .ulpi_stp(ulpi_stp),
    .ulpi_data_in(ulpi_data_in),
    .ulpi_data_out(ulpi_data_out),
    .ulpi_data_oe(ulpi_data_oe),
    .rxcmd_valid(rxcmd_valid),
    .rxcmd(rxcmd)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm,
                      input logic a, input logic e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endtask

  task automatic chk8(input string nm,
                      input logic [7:0] a,
                      input logic [7:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [5:0] a,
                       input logic [7:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    cyc();
    bus.req_valid = 1'b0;
  endtask

  // PHY side of a read, starting in the TXCMD cycle
  task automatic read_body(input logic [7:0] d);
    ulpi_nxt = 1'b1;
    cyc();
    ulpi_nxt = 1'b0;
    @(negedge clk);
    chk1("rturn_oe", ulpi_data_oe, 1'b0);
    ulpi_dir = 1'b1;
    cyc();
    ulpi_data_in = d;
    cyc();
    ulpi_dir     = 1'b0;
    ulpi_data_in = 8'h00;
    @(negedge clk);
    chk1("rd_early", bus.rsp_valid, 1'b0);
    cyc();
    @(negedge clk);
    chk1("rd_latency", bus.rsp_valid, 1'b1);
    cyc();
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (reset && bus.rsp_valid) begin
      if (rq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 want none");
      end else begin
        e = rq.pop_front();
        chk1("rsp_error", bus.rsp_error, e.err);
        if (e.chk_d) chk8("rsp_rdata", bus.rsp_rdata, e.d);
      end
    end
    if (reset && rxcmd_valid) begin
      if (xq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rx_unexpected: got rxcmd_valid=1 want none");
      end else begin
        chk8("rxcmd", rxcmd, xq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  stp_n;
    int  lat;
    bit  got;
    reset         = 1'b0;
    ulpi_dir      = 1'b0;
    ulpi_nxt      = 1'b0;
    ulpi_data_in  = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 6'd0;
    bus.req_wdata = 8'd0;
    repeat (3) cyc();
    @(negedge clk);
    chk1("rst_ready", bus.req_ready, 1'b1);
    chk1("rst_stp", ulpi_stp, 1'b0);
    chk1("rst_oe", ulpi_data_oe, 1'b0);
    chk8("rst_data", ulpi_data_out, 8'h00);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk8("rst_rdata", bus.rsp_rdata, 8'h00);
    chk1("rst_rsp_error", bus.rsp_error, 1'b0);
    chk1("rst_rx_valid", rxcmd_valid, 1'b0);
    chk8("rst_rxcmd", rxcmd, 8'h00);
    reset = 1'b1;
    cyc();

    // register write 0x0A <= 0x55
    rq.push_back({1'b0, 8'h00, 1'b0});
    issue(1'b1, 6'h0A, 8'h55);
    ulpi_nxt = 1'b1;
    @(negedge clk);
    chk8("wr_txcmd", ulpi_data_out, 8'h8A);
    chk1("wr_txcmd_oe", ulpi_data_oe, 1'b1);
    chk1("wr_busy", bus.req_ready, 1'b0);
    cyc();
    @(negedge clk);
    chk8("wr_data", ulpi_data_out, 8'h55);
    cyc();
    ulpi_nxt = 1'b0;
    @(negedge clk);
    chk1("wr_stp", ulpi_stp, 1'b1);
    chk8("wr_stp_data", ulpi_data_out, 8'h00);
    cyc();
    @(negedge clk);
    chk1("wr_stp_once", ulpi_stp, 1'b0);
    cyc();

    // register read 0x00 -> 0x24
    rq.push_back({1'b1, 8'h24, 1'b0});
    issue(1'b0, 6'h00, 8'h00);
    @(negedge clk);
    chk8("rd_txcmd", ulpi_data_out, 8'hC0);
    read_body(8'h24);

    // read 0x03, one dir abort, then success returning 0x00
    rq.push_back({1'b1, 8'h00, 1'b0});
    issue(1'b0, 6'h03, 8'h00);
    ulpi_dir = 1'b1;
    @(negedge clk);
    chk1("abort_oe_same_cycle", ulpi_data_oe, 1'b0);
    cyc();
    ulpi_dir = 1'b0;
    cyc();
    @(negedge clk);
    chk8("retry_txcmd", ulpi_data_out, 8'hC3);
    chk1("retry_oe", ulpi_data_oe, 1'b1);
    read_body(8'h00);

    // four consecutive aborts exhaust the retries
    rq.push_back({1'b0, 8'h00, 1'b1});
    issue(1'b0, 6'h05, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk8("abort_loop_txcmd", ulpi_data_out, 8'hC5);
      ulpi_dir = 1'b1;
      cyc();
      ulpi_dir = 1'b0;
      cyc();
    end
    @(negedge clk);
    chk1("abort_exhaust_valid", bus.rsp_valid, 1'b1);
    cyc();

    // silent PHY: single stp then error
    rq.push_back({1'b0, 8'h00, 1'b1});
    issue(1'b0, 6'h07, 8'h00);
    stp_n = 0;
    lat   = 0;
    got   = 1'b0;
    for (int k = 1; k <= 400 && !got; k++) begin
      @(negedge clk);
      if (ulpi_stp) stp_n++;
      if (bus.rsp_valid) begin
        got = 1'b1;
        lat = k;
      end
      cyc();
    end
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL tmo_rsp: got no rsp_valid want one within 400 cycles");
    end
    n_vec++;
    if (stp_n != 1) begin
      n_bad++;
      $display("FAIL tmo_stp: got %0d stp cycles want 1", stp_n);
    end
    n_vec++;
    if (lat < TMO_C || lat > TMO_C + 4) begin
      n_bad++;
      $display("FAIL tmo_latency: got %0d want %0d..%0d",
               lat, TMO_C, TMO_C + 4);
    end

    // RX CMD while idle, packet byte ignored
    ulpi_dir = 1'b1;
    @(negedge clk);
    chk1("rx_ready_low", bus.req_ready, 1'b0);
    cyc();
    ulpi_data_in = 8'h4C;
    xq.push_back(8'h4C);
    cyc();
    ulpi_nxt     = 1'b1;
    ulpi_data_in = 8'h99;
    @(negedge clk);
    chk1("rx_ready_low2", bus.req_ready, 1'b0);
    cyc();
    ulpi_nxt     = 1'b0;
    ulpi_dir     = 1'b0;
    ulpi_data_in = 8'h00;
    cyc();
    @(negedge clk);
    chk8("rx_hold", rxcmd, 8'h4C);
    chk1("rx_ready_back", bus.req_ready, 1'b1);
    cyc();

    // reset while in RDATA
    issue(1'b0, 6'h01, 8'h00);
    ulpi_nxt = 1'b1;
    cyc();
    ulpi_nxt = 1'b0;
    ulpi_dir = 1'b1;
    cyc();
    ulpi_data_in = 8'h77;
    reset        = 1'b0;
    cyc();
    reset        = 1'b1;
    ulpi_dir     = 1'b0;
    ulpi_data_in = 8'h00;
    @(negedge clk);
    chk1("mrst_ready", bus.req_ready, 1'b1);
    chk1("mrst_oe", ulpi_data_oe, 1'b0);
    chk1("mrst_stp", ulpi_stp, 1'b0);
    chk8("mrst_data", ulpi_data_out, 8'h00);
    chk1("mrst_rsp_valid", bus.rsp_valid, 1'b0);
    chk8("mrst_rdata", bus.rsp_rdata, 8'h00);
    chk8("mrst_rxcmd", rxcmd, 8'h00);
    cyc();
    cyc();
    rq.push_back({1'b1, 8'h3C, 1'b0});
    issue(1'b0, 6'h02, 8'h00);
    @(negedge clk);
    chk8("post_rst_txcmd", ulpi_data_out, 8'hC2);
    read_body(8'h3C);

    repeat (4) cyc();
    n_vec++;
    if (rq.size() != 0) begin
      n_bad++;
      $display("FAIL rsp_missing: got %0d pending want 0", rq.size());
    end
    n_vec++;
    if (xq.size() != 0) begin
      n_bad++;
      $display("FAIL rx_missing: got %0d pending want 0", xq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
